// File: rtl/vga_bar_pkg.sv
// vga_bar_pkg
//   Shared types and constants for the VGA bar-graph history scheduler.
//   - state_t   : commit FSM encoding (IDLE / PEND / SHIFT)
//   - COORD_W   : screen coordinate width (10 bits)
//   - SAMPLE_W  : raw sample width (12 bits)
//   - V_ACTIVE_DEF / Y_BASE_DEF : default first blanking line and graph baseline
//   - bar_top() : converts a sample to a bar-top Y coordinate, saturating at 0
package vga_bar_pkg;

   localparam int COORD_W      = 10;
   localparam int SAMPLE_W     = 12;
   localparam int V_ACTIVE_DEF = 480;
   localparam int Y_BASE_DEF   = 120;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PEND  = 2'd1,
      ST_SHIFT = 2'd2
   } state_t;

   // Taller bars have smaller Y. The shifted sample is narrowed to the
   // coordinate width, then subtracted in one extra signed bit so a bar
   // taller than the baseline clamps at line 0 instead of wrapping.
   function automatic logic [COORD_W-1:0] bar_top(
      input logic [SAMPLE_W-1:0] sample,
      input logic [COORD_W-1:0]  y_base,
      input int unsigned         sh
   );
      logic signed [COORD_W:0] diff;
      diff = $signed({1'b0, y_base}) - $signed({1'b0, COORD_W'(sample >> sh)});
      return diff[COORD_W] ? '0 : diff[COORD_W-1:0];
   endfunction

endpackage

// File: rtl/vga_bar_win.sv
// vga_bar_win
//   Window capture for the bar scheduler. Counts update ticks, tracks the
//   window peak (or an IIR-smoothed sample when VGA_BAR_IIR_EN is defined)
//   and presents the bar-top value together with a one-cycle close strobe.
//   Ports:
//     clk_sys      in   clock, rising edge
//     rst_b        in   asynchronous active-low reset
//     sample       in   raw 12-bit sample
//     sample_valid in   sample strobe
//     upd_tick     in   update tick
//     close        out  window closes this cycle (combinational)
//     close_val    out  bar-top Y for the closing window (combinational)
//   Macro VGA_BAR_IIR_EN: replaces the per-window peak with a 16-bit IIR
//   accumulator that persists across windows.
module vga_bar_win
   import vga_bar_pkg::*;
#(
   parameter int UPD_DIV  = 60,
   parameter int Y_BASE   = Y_BASE_DEF,
   parameter int SCALE_SH = 5,
   parameter int AVG_SH   = 3
) (
   input  logic                clk_sys,
   input  logic                rst_b,
   input  logic [SAMPLE_W-1:0] sample,
   input  logic                sample_valid,
   input  logic                upd_tick,
   output logic                close,
   output logic [COORD_W-1:0]  close_val
);

   localparam logic [9:0]         DIV_LAST = 10'(UPD_DIV - 1);
   localparam logic [COORD_W-1:0] Y_BASE_C = COORD_W'(Y_BASE);

   if (UPD_DIV < 1 || UPD_DIV > 1023) begin : g_bad_div
      $error("vga_bar_win: UPD_DIV out of range 1..1023");
   end
   if (AVG_SH < 0 || AVG_SH > 15) begin : g_bad_avg
      $error("vga_bar_win: AVG_SH out of range 0..15");
   end

   logic [9:0] div_cnt;

   assign close = upd_tick && (div_cnt == DIV_LAST);

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b)
         div_cnt <= '0;
      else if (upd_tick)
         div_cnt <= close ? '0 : div_cnt + 10'd1;
   end

`ifdef VGA_BAR_IIR_EN
   // acc holds the smoothed sample scaled by 16; it is never cleared at
   // window close, so an empty window simply reports the current average.
   logic [15:0]        acc;
   logic signed [16:0] delta;

   assign delta = $signed({1'b0, sample, 4'b0000}) - $signed({1'b0, acc});

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b)
         acc <= '0;
      else if (sample_valid)
         acc <= 16'($signed({1'b0, acc}) + (delta >>> AVG_SH));
   end

   assign close_val = bar_top(acc[15:4], Y_BASE_C, SCALE_SH);
`else
   // A sample arriving on the close cycle belongs to the next window.
   logic [SAMPLE_W-1:0] peak;

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b)
         peak <= '0;
      else if (close)
         peak <= sample_valid ? sample : '0;
      else if (sample_valid && (sample > peak))
         peak <= sample;
   end

   assign close_val = bar_top(peak, Y_BASE_C, SCALE_SH);
`endif

endmodule

// File: rtl/vga_bar_sched.sv
// vga_bar_sched
//   Scheduler feeding the VGA bar-graph history buffer. Decimates samples
//   into windows (vga_bar_win) and commits at most one history shift per
//   frame, only during vertical blanking, so the bars never tear.
//   Ports:
//     iVGA_CLK  in   pixel clock, rising edge
//     iRST_n    in   asynchronous active-low reset
//     iVGA_Y    in   current scan line
//     iD        in   raw 12-bit sample
//     iD_valid  in   sample strobe
//     iDupd     in   update tick
//     oShift    out  one-cycle history shift pulse, entry 0 takes oBarVal
//     oBarVal   out  bar-top Y for the new entry, held between shifts
//     oPending  out  committed value waiting for blanking
//     oOverrun  out  sticky: a window closed while a value was still pending
//   Macro VGA_BAR_IIR_EN: IIR smoothing instead of per-window peak.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | nothing pending
//   ST_PEND  | window value committed, waiting for an unused blanking
//   ST_SHIFT | one-cycle history shift, oBarVal carries the value
module vga_bar_sched
   import vga_bar_pkg::*;
#(
   parameter int UPD_DIV  = 60,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int Y_BASE   = Y_BASE_DEF,
   parameter int SCALE_SH = 5,
   parameter int AVG_SH   = 3
) (
   input  logic                iVGA_CLK,
   input  logic                iRST_n,
   input  logic [COORD_W-1:0]  iVGA_Y,
   input  logic [SAMPLE_W-1:0] iD,
   input  logic                iD_valid,
   input  logic                iDupd,
   output logic                oShift,
   output logic [COORD_W-1:0]  oBarVal,
   output logic                oPending,
   output logic                oOverrun
);

   localparam logic [COORD_W-1:0] V_ACTIVE_C = COORD_W'(V_ACTIVE);
   localparam logic [COORD_W-1:0] Y_BASE_C   = COORD_W'(Y_BASE);

   state_t               state;
   state_t               state_nxt;
   logic                 win_close;
   logic [COORD_W-1:0]   win_val;
   logic [COORD_W-1:0]   pend_val;
   logic [COORD_W-1:0]   bar_val;
   logic                 frame_done;
   logic                 overrun;
   logic                 blank;
   logic                 go_shift;

   vga_bar_win #(
      .UPD_DIV  (UPD_DIV),
      .Y_BASE   (Y_BASE),
      .SCALE_SH (SCALE_SH),
      .AVG_SH   (AVG_SH)
   ) u_win (
      .clk_sys      (iVGA_CLK),
      .rst_b        (iRST_n),
      .sample       (iD),
      .sample_valid (iD_valid),
      .upd_tick     (iDupd),
      .close        (win_close),
      .close_val    (win_val)
   );

   assign blank = (iVGA_Y >= V_ACTIVE_C);

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // A close arriving in PEND has priority over the shift: the newer value
   // replaces the old one and the shift follows on the next eligible cycle.
   always_comb begin
      state_nxt = state;
      go_shift  = 1'b0;
      case (state)
         ST_IDLE:  if (win_close) state_nxt = ST_PEND;
         ST_PEND:  if (!win_close && blank && !frame_done) begin
                      state_nxt = ST_SHIFT;
                      go_shift  = 1'b1;
                   end
         ST_SHIFT: state_nxt = win_close ? ST_PEND : ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         pend_val   <= Y_BASE_C;
         bar_val    <= Y_BASE_C;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (win_close)
            pend_val <= win_val;
         // Loaded on entry to SHIFT so oBarVal is valid alongside oShift.
         if (go_shift)
            bar_val <= pend_val;
         if (state == ST_SHIFT)
            frame_done <= 1'b1;
         else if (!blank)
            frame_done <= 1'b0;
         if ((state == ST_PEND) && win_close)
            overrun <= 1'b1;
      end
   end

   assign oShift   = (state == ST_SHIFT);
   assign oPending = (state == ST_PEND);
   assign oBarVal  = bar_val;
   assign oOverrun = overrun;

endmodule

// File: tb/tb_vga_bar_sched.sv
// tb_vga_bar_sched
//   Directed bench for vga_bar_sched with UPD_DIV=4 and default scaling.
//   Expected bar values are hand-computed: Y_BASE - (peak >> 5), clamped at 0.
module tb_vga_bar_sched;

   logic        clk;
   logic        rst_n;
   logic [9:0]  vga_y;
   logic [11:0] d;
   logic        d_valid;
   logic        dupd;
   logic        shift;
   logic [9:0]  bar_val;
   logic        pending;
   logic        overrun;

   int vectors     = 0;
   int miscompares = 0;
   int shift_cnt   = 0;
   int base_cnt;

   vga_bar_sched #(
      .UPD_DIV  (4),
      .V_ACTIVE (480),
      .Y_BASE   (120),
      .SCALE_SH (5),
      .AVG_SH   (3)
   ) dut (
      .iVGA_CLK (clk),
      .iRST_n   (rst_n),
      .iVGA_Y   (vga_y),
      .iD       (d),
      .iD_valid (d_valid),
      .iDupd    (dupd),
      .oShift   (shift),
      .oBarVal  (bar_val),
      .oPending (pending),
      .oOverrun (overrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (shift) shift_cnt <= shift_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic chk10(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [11:0] v);
      d       = v;
      d_valid = 1'b1;
      tick();
      d_valid = 1'b0;
   endtask

   task automatic upd(input int n);
      for (int i = 0; i < n; i++) begin
         dupd = 1'b1;
         tick();
         dupd = 1'b0;
      end
   endtask

   // Enter blanking, wait (bounded) for the shift and check its value.
   task automatic blank_shift(input string tag, input logic [9:0] exp);
      bit seen;
      seen  = 1'b0;
      vga_y = 10'd480;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         if (shift) seen = 1'b1;
      end
      chk1({tag, "_shift"}, seen, 1'b1);
      chk10({tag, "_val"}, bar_val, exp);
      chk1({tag, "_pend_low"}, pending, 1'b0);
      tick();
   endtask

   initial begin
      rst_n   = 1'b0;
      vga_y   = 10'd100;
      d       = '0;
      d_valid = 1'b0;
      dupd    = 1'b0;
      tick();
      tick();
      chk1 ("rst_shift",   shift,   1'b0);
      chk10("rst_barval",  bar_val, 10'd120);
      chk1 ("rst_pending", pending, 1'b0);
      chk1 ("rst_overrun", overrun, 1'b0);
      rst_n = 1'b1;
      tick();

`ifdef VGA_BAR_IIR_EN
      for (int i = 0; i < 8; i++) send(12'h800);
      upd(4);
      chk1("iir_pending", pending, 1'b1);
      blank_shift("iir_8x800", 10'd78);
      vga_y = 10'd100;
      tick();
      upd(4);
      blank_shift("iir_empty", 10'd78);
`else
      // Basic window: peak 0x3C0 -> 120 - 30 = 90
      send(12'h100);
      send(12'h3C0);
      send(12'h200);
      upd(3);
      chk1("win_not_closed", pending, 1'b0);
      upd(1);
      chk1("win_pending", pending, 1'b1);
      chk1("win_no_shift_visible", shift, 1'b0);
      blank_shift("basic", 10'd90);
      chk_int("basic_count", shift_cnt, 1);

      // Saturation: 0xFFF >> 5 = 127 > 120
      vga_y = 10'd100;
      send(12'hFFF);
      upd(4);
      chk10("hold_barval", bar_val, 10'd90);
      blank_shift("sat", 10'd0);

      // Overrun: two closes while visible, second value wins (0x640 -> 70)
      vga_y = 10'd100;
      send(12'h200);
      upd(4);
      chk1("ovr_first_close", overrun, 1'b0);
      send(12'h640);
      upd(4);
      chk1("ovr_set", overrun, 1'b1);
      chk1("ovr_pending", pending, 1'b1);
      base_cnt = shift_cnt;
      blank_shift("ovr", 10'd70);
      for (int i = 0; i < 10; i++) tick();
      chk_int("ovr_one_shift", shift_cnt, base_cnt + 1);

      // Close mid-blank after this frame's shift: must wait for next frame
      send(12'h0A0);
      upd(4);
      chk1("midblank_pending", pending, 1'b1);
      for (int i = 0; i < 20; i++) begin
         vga_y = 10'(481 + i);
         tick();
      end
      chk_int("midblank_no_shift", shift_cnt, base_cnt + 1);
      chk1("midblank_still_pend", pending, 1'b1);
      vga_y = 10'd100;
      tick();
      blank_shift("next_frame", 10'd115);
      chk_int("next_frame_count", shift_cnt, base_cnt + 2);

      // Empty window -> baseline
      vga_y = 10'd100;
      tick();
      upd(4);
      blank_shift("empty", 10'd120);

      // Sample coincident with close starts the next window
      vga_y = 10'd100;
      tick();
      send(12'h400);
      upd(3);
      d       = 12'hC00;
      d_valid = 1'b1;
      dupd    = 1'b1;
      tick();
      d_valid = 1'b0;
      dupd    = 1'b0;
      blank_shift("coinc_old", 10'd88);
      vga_y = 10'd100;
      tick();
      upd(4);
      blank_shift("coinc_new", 10'd24);

      // Reset while pending: value lost, no shift afterwards
      vga_y = 10'd100;
      tick();
      send(12'h300);
      upd(4);
      chk1("prerst_pending", pending, 1'b1);
      base_cnt = shift_cnt;
      #3 rst_n = 1'b0;
      #1;
      chk1 ("midrst_pending", pending, 1'b0);
      chk1 ("midrst_overrun", overrun, 1'b0);
      chk10("midrst_barval",  bar_val, 10'd120);
      chk1 ("midrst_shift",   shift,   1'b0);
      tick();
      rst_n = 1'b1;
      vga_y = 10'd480;
      for (int i = 0; i < 10; i++) tick();
      chk_int("postrst_no_shift", shift_cnt, base_cnt);
      chk1("postrst_pending", pending, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
